// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection and break handling.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data and stop bits.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  r_sync;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_perr;
    logic        w_rxs;
    logic        w_tick;
    logic        w_perr;
    logic [2:0]  w_after_data;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    assign w_perr       = ^{r_shift, r_par};
    assign w_after_data = S_PARITY;
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) r_par <= 1'b0;
        else if (r_state == S_PARITY && w_tick) r_par <= w_rxs;
`else
    assign w_perr       = 1'b0;
    assign w_after_data = S_STOP;
`endif

    assign w_rxs      = r_sync[1];
    assign w_tick     = r_cnt == 16'd0;
    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign busy       = r_state != S_IDLE;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            case (r_state)
                S_IDLE: if (!w_rxs) begin
                    r_cnt   <= HALF;
                    r_state <= S_START;
                end
                S_START: if (!w_tick) r_cnt <= r_cnt - 16'd1;
                else if (w_rxs) r_state <= S_IDLE;
                else begin
                    r_cnt   <= FULL;
                    r_idx   <= 3'd0;
                    r_state <= S_DATA;
                end
                S_DATA: if (!w_tick) r_cnt <= r_cnt - 16'd1;
                else begin
                    r_cnt   <= FULL;
                    r_shift <= {w_rxs, r_shift[7:1]};
                    r_idx   <= r_idx + 3'd1;
                    if (r_idx == 3'd7) r_state <= w_after_data;
                end
                S_PARITY: if (!w_tick) r_cnt <= r_cnt - 16'd1;
                else begin
                    r_cnt   <= FULL;
                    r_state <= S_STOP;
                end
                S_STOP: if (!w_tick) r_cnt <= r_cnt - 16'd1;
                else if (w_rxs) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    r_perr  <= w_perr;
                    r_state <= S_IDLE;
                end else begin
                    r_ferr  <= 1'b1;
                    r_state <= S_WAIT_HIGH;
                end
                // A held-low break parks here so it reports only one frame error.
                S_WAIT_HIGH: if (w_rxs) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
